// File: rtl/frame_timer_pkg.sv
// Shared types and constants for the receive-frame bit-timing sequencer.
package frame_timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HALF = 2'd1,
      DATA = 2'd2,
      STOP = 2'd3
   } state_t;

   localparam int MIN_CLKS_PER_BIT = 2;

endpackage

// File: rtl/flex_counter.sv
// Saturating up-counter with synchronous clear; rollover_flag is high while
// the count equals rollover_val.
module flex_counter #(
   parameter int NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    count_enable,
   input  logic [NUM_CNT_BITS-1:0] rollover_val,
   output logic [NUM_CNT_BITS-1:0] count_out,
   output logic                    rollover_flag
);

   localparam logic [NUM_CNT_BITS-1:0] ONE = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         count_out <= '0;
      else if (clear)
         count_out <= '0;
      else if (count_enable && (count_out != rollover_val))
         count_out <= count_out + ONE;
   end

   assign rollover_flag = (count_out == rollover_val);

endmodule

// File: rtl/frame_timer.sv
// Times one serial receive frame after a start-bit detect: half period to the
// start-bit centre, one strobe per data bit, then a stop-bit strobe.
import frame_timer_pkg::*;

module frame_timer #(
   parameter int CLK_CNT_BITS = 8,
   parameter int BIT_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    abort,
   input  logic [CLK_CNT_BITS-1:0] clks_per_bit,
   input  logic [BIT_CNT_BITS-1:0] data_bits,
   output logic                    busy,
   output logic                    shift_strobe,
   output logic                    stop_strobe,
   output logic                    frame_done,
   output logic [BIT_CNT_BITS-1:0] bit_index
);

   localparam logic [CLK_CNT_BITS-1:0] P_MIN = CLK_CNT_BITS'(MIN_CLKS_PER_BIT);
   localparam logic [CLK_CNT_BITS-1:0] ONE_C = {{(CLK_CNT_BITS-1){1'b0}}, 1'b1};
   localparam logic [BIT_CNT_BITS:0]   ONE_B = {{BIT_CNT_BITS{1'b0}}, 1'b1};

   state_t                  state, state_nx;
   logic [CLK_CNT_BITS-1:0] p_lat, p_sel, half_len, clk_roll, clk_cnt;
   logic [BIT_CNT_BITS-1:0] n_lat, bit_cnt;
   logic [BIT_CNT_BITS:0]   bit_cnt_inc;
   logic                    clk_flag, bit_flag, last_bit, start_ok;
   logic                    phase_end, shift_nx, stop_nx;

   assign p_sel       = (clks_per_bit < P_MIN) ? P_MIN : clks_per_bit;
   assign half_len    = p_lat >> 1;
   // Phase of length L is entered with the counter at 0 and ends on the edge
   // after the count reaches L-1, so the rollover target is one below L.
   assign clk_roll    = (state == HALF) ? (half_len - ONE_C) : (p_lat - ONE_C);
   assign bit_cnt_inc = {1'b0, bit_cnt} + ONE_B;
   assign last_bit    = (bit_cnt_inc == {1'b0, n_lat});
   assign start_ok    = (state == IDLE) && start && !abort;

   flex_counter #(.NUM_CNT_BITS(CLK_CNT_BITS)) u_clk_cnt (
      .clk           (clk),
      .n_rst         (~rst),
      .clear         (abort | start_ok | phase_end),
      .count_enable  (state != IDLE),
      .rollover_val  (clk_roll),
      .count_out     (clk_cnt),
      .rollover_flag (clk_flag)
   );

   flex_counter #(.NUM_CNT_BITS(BIT_CNT_BITS)) u_bit_cnt (
      .clk           (clk),
      .n_rst         (~rst),
      .clear         (abort | start_ok),
      .count_enable  (shift_nx),
      .rollover_val  (n_lat),
      .count_out     (bit_cnt),
      .rollover_flag (bit_flag)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      phase_end = 1'b0;
      shift_nx  = 1'b0;
      stop_nx   = 1'b0;
      if (abort) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE: if (start) state_nx = HALF;
            HALF: if (clk_flag) begin
               phase_end = 1'b1;
               // bit counter is still 0 here, so its flag means N == 0
               state_nx  = bit_flag ? STOP : DATA;
            end
            DATA: if (clk_flag) begin
               phase_end = 1'b1;
               shift_nx  = 1'b1;
               if (last_bit) state_nx = STOP;
            end
            STOP: if (clk_flag) begin
               phase_end = 1'b1;
               stop_nx   = 1'b1;
               state_nx  = IDLE;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_lat        <= P_MIN;
         n_lat        <= '0;
         busy         <= 1'b0;
         shift_strobe <= 1'b0;
         stop_strobe  <= 1'b0;
         frame_done   <= 1'b0;
         bit_index    <= '0;
      end else begin
         if (start_ok) begin
            p_lat <= p_sel;
            n_lat <= data_bits;
         end
         busy         <= (state != IDLE) && !abort;
         shift_strobe <= shift_nx;
         stop_strobe  <= stop_nx;
         frame_done   <= stop_nx;
         // trails the bit counter by one cycle, so it reads j after strobe j
         if (abort || start_ok)
            bit_index <= '0;
         else if (state != IDLE)
            bit_index <= bit_cnt;
      end
   end

endmodule

// File: tb/tb_frame_timer.sv
// Directed bench for frame_timer: frame timing, period/bit-count corners,
// abort, ignored mid-frame inputs, reset and back-to-back frames.
module tb_frame_timer;

   logic       clk, rst, start, abort;
   logic [7:0] clks_per_bit;
   logic [3:0] data_bits;
   logic       busy, shift_strobe, stop_strobe, frame_done;
   logic [3:0] bit_index;

   int checks = 0;
   int errors = 0;

   frame_timer #(.CLK_CNT_BITS(8), .BIT_CNT_BITS(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .clks_per_bit (clks_per_bit),
      .data_bits    (data_bits),
      .busy         (busy),
      .shift_strobe (shift_strobe),
      .stop_strobe  (stop_strobe),
      .frame_done   (frame_done),
      .bit_index    (bit_index)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] obs_vec();
      return {busy, shift_strobe, stop_strobe, frame_done, bit_index};
   endfunction

   // Expected {busy,shift,stop,done,bit_index} in cycle k (k >= 1) of a frame.
   function automatic logic [7:0] exp_vec(int k, int p, int n);
      int pe, h, e, j;
      logic b, s, t;
      logic [3:0] idx;
      pe = (p < 2) ? 2 : p;
      h  = pe / 2;
      e  = h + (n + 1) * pe;
      b  = (k >= 1) && (k <= e);
      s  = (k > h) && (((k - h) % pe) == 0) && (((k - h) / pe) <= n);
      t  = (k == e);
      j  = (k - h - 1 < 0) ? 0 : (k - h - 1) / pe;
      if (j > n) j = n;
      idx = j[3:0];
      return {b, s, t, t, idx};
   endfunction

   // Leaves the bench #1 after E0 (cycle 0).
   task automatic start_frame(input int p, input int n);
      clks_per_bit = p[7:0];
      data_bits    = n[3:0];
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] o;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         o = obs_vec();
         checks++;
         if (o !== 8'h00) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d got %b exp %b", k, o, 8'h00);
         end
      end
      start_frame(4, 8);
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
      end
      #2 rst = 1'b1;
      #1 o = obs_vec();
      checks++;
      if (o !== 8'h00) begin
         errors++;
         $display("FAIL reset_midframe got %b exp %b", o, 8'h00);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         o = obs_vec();
         checks++;
         if (o !== 8'h00) begin
            errors++;
            $display("FAIL reset_release got %b exp %b", o, 8'h00);
         end
      end
   endtask

   task automatic test_frame(input int p, input int n);
      logic [7:0] o, e;
      int len;
      len = ((p < 2) ? 1 : p / 2) + (n + 1) * ((p < 2) ? 2 : p);
      start_frame(p, n);
      for (int k = 1; k <= len + 3; k++) begin
         @(posedge clk); #1;
         o = obs_vec();
         e = exp_vec(k, p, n);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL frame_p%0d_n%0d cyc=%0d got %b exp %b", p, n, k, o, e);
         end
      end
   endtask

   // P=4, N=8 with hand-computed landmarks: 8 shifts, stop at 38, busy 1..38.
   task automatic test_p4n8();
      logic [7:0] o, e;
      int nshift, stop_cyc, last_busy;
      nshift = 0; stop_cyc = -1; last_busy = -1;
      start_frame(4, 8);
      for (int k = 1; k <= 42; k++) begin
         @(posedge clk); #1;
         o = obs_vec();
         e = exp_vec(k, 4, 8);
         if (shift_strobe) nshift++;
         if (stop_strobe && frame_done) stop_cyc = k;
         if (busy) last_busy = k;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL p4n8 cyc=%0d got %b exp %b", k, o, e);
         end
         if (k == 35) begin
            checks++;
            if (bit_index !== 4'd8) begin
               errors++;
               $display("FAIL p4n8_index35 got %0d exp 8", bit_index);
            end
         end
      end
      checks++;
      if (nshift != 8) begin
         errors++;
         $display("FAIL p4n8_shift_count got %0d exp 8", nshift);
      end
      checks++;
      if (stop_cyc != 38) begin
         errors++;
         $display("FAIL p4n8_stop_cycle got %0d exp 38", stop_cyc);
      end
      checks++;
      if (last_busy != 38) begin
         errors++;
         $display("FAIL p4n8_busy_end got %0d exp 38", last_busy);
      end
   endtask

   task automatic test_abort();
      logic [7:0] o, e;
      start_frame(4, 8);
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk); #1;
         if (k == 16) abort = 1'b0;
         o = obs_vec();
         e = (k <= 15) ? exp_vec(k, 4, 8) : 8'h00;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL abort cyc=%0d got %b exp %b", k, o, e);
         end
         if (k == 15) abort = 1'b1;
      end
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1;
         o = obs_vec();
         checks++;
         if (o !== 8'h00) begin
            errors++;
            $display("FAIL abort_start cyc=%0d got %b exp %b", k, o, 8'h00);
         end
      end
   endtask

   task automatic test_midframe();
      logic [7:0] o, e;
      start_frame(4, 8);
      for (int k = 1; k <= 42; k++) begin
         @(posedge clk); #1;
         start = (k == 12);
         if (k == 13) begin
            clks_per_bit = 8'd10;
            data_bits    = 4'd3;
         end
         o = obs_vec();
         e = exp_vec(k, 4, 8);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL midframe cyc=%0d got %b exp %b", k, o, e);
         end
      end
      start = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [7:0] o, e;
      start_frame(4, 8);
      for (int k = 1; k <= 38; k++) begin
         @(posedge clk); #1;
         o = obs_vec();
         e = exp_vec(k, 4, 8);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL b2b_first cyc=%0d got %b exp %b", k, o, e);
         end
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 41; k++) begin
         @(posedge clk); #1;
         o = obs_vec();
         e = exp_vec(k, 4, 8);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL b2b_second cyc=%0d got %b exp %b", k, o, e);
         end
      end
   endtask

   initial begin
      rst          = 1'b1;
      start        = 1'b0;
      abort        = 1'b0;
      clks_per_bit = 8'd4;
      data_bits    = 4'd8;
      test_reset();
      test_frame(5, 2);
      test_p4n8();
      test_frame(0, 3);
      test_frame(1, 3);
      test_frame(2, 3);
      test_frame(4, 0);
      test_frame(7, 1);
      test_abort();
      test_midframe();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/frame_timer.md
# frame_timer

Bit-timing sequencer for the serial receive path. After a start-bit detect pulse, it times one frame: half a bit period to the start-bit centre, then one strobe per data bit, then one stop-bit strobe. Clock-per-bit and bit-per-frame counting run on two counter instances that this block clears and enables. Its strobes drive the receive shift register and the stop-bit checker.

## Interface
- CLK_CNT_BITS, 8: width of the clocks-per-bit count
- BIT_CNT_BITS, 4: width of the data-bit count
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  start-bit detected; sampled only in IDLE
- abort  in  1  synchronous frame abort, any state
- clks_per_bit  in  CLK_CNT_BITS  bit period P in clocks; latched at start
- data_bits  in  BIT_CNT_BITS  data bits per frame N; latched at start
- busy  out  1  frame in progress
- shift_strobe  out  1  one-cycle pulse at each data-bit centre
- stop_strobe  out  1  one-cycle pulse at stop-bit centre
- frame_done  out  1  one-cycle pulse, coincident with stop_strobe
- bit_index  out  BIT_CNT_BITS  shift strobes issued in the current frame

## Operation
- States: IDLE, HALF, DATA, STOP.
- IDLE, start=1, abort=0 at edge E0:
  - Latch P = max(clks_per_bit, 2) and N = data_bits.
  - Clear both counters, bit_index <= 0, go HALF.
- HALF: count H = P >> 1 clocks, then go DATA. If N = 0, go STOP instead.
- DATA: count P clocks, then pulse shift_strobe and increment bit_index.
  - After the Nth strobe, go STOP.
  - Otherwise clear the clock counter and stay in DATA.
- STOP: count P clocks, then pulse stop_strobe and frame_done, and return to IDLE.
- The clock counter is cleared on every phase entry, so there is no carry between phases.
- start outside IDLE is ignored. No queueing, no restart.
- abort:
  - Takes effect at the next edge. State goes to IDLE, counters clear, bit_index <= 0.
  - No strobe or frame_done is emitted in the cycle after abort is sampled.
  - If abort and start are both sampled in IDLE, abort wins and no frame starts.
- clks_per_bit and data_bits changing mid-frame have no effect, because the values were latched at start.
- Width rules:
  - H and P comparisons are unsigned at CLK_CNT_BITS.
  - bit_index saturates at N and never wraps inside a frame.

## Timing
- Reset values:
  - state = IDLE
  - busy = 0, shift_strobe = 0, stop_strobe = 0, frame_done = 0, bit_index = 0
  - both counters 0
- All outputs are registered.
- Cycle k means the cycle beginning k edges after E0.
- busy is high in cycles 1 through H+(N+1)·P inclusive, and low from the following cycle.
- shift_strobe is high in cycle H + j·P for j = 1..N.
- bit_index equals j starting from cycle H + j·P + 1.
- stop_strobe and frame_done are high in cycle H + (N+1)·P.
- A new start is accepted no earlier than edge H+(N+1)·P+1.
- Back-to-back frames leave zero idle cycles beyond that edge.
- Reset asserted mid-frame forces all outputs to their reset values immediately (asynchronous), with no partial pulse.

## Structure
- Package frame_timer_pkg holds:
  - the state enum typedef (IDLE, HALF, DATA, STOP), 2-bit encoding
  - the minimum-period constant MIN_CLKS_PER_BIT = 2
- Sub-module: two flex_counter instances.
  - Clock counter: NUM_CNT_BITS = CLK_CNT_BITS, rollover_val = H or P depending on phase.
  - Bit counter: NUM_CNT_BITS = BIT_CNT_BITS, rollover_val = N.
  - Drive each instance's n_rst from ~rst.
  - Use their clear for phase entry and abort, and count_enable for counting.
  - Use their rollover_flag to advance the FSM, adjusted so the exact cycle numbers above hold.
- Target 150–250 lines including the package.

## Test plan
- Reset, then idle 10 cycles: every output is 0 and bit_index = 0. Assert rst during cycle 20 of a frame: outputs go 0 at once, and the block is in IDLE after release.
- P=4, N=8, start pulse at E0:
  - shift_strobe in cycles 6, 10, …, 34 (8 pulses).
  - stop_strobe and frame_done in cycle 38.
  - busy in cycles 1–38; bit_index reads 8 in cycles 35–38.
- P=5, N=2: H=2. shift_strobe in cycles 7 and 12; stop_strobe in cycle 17. Edge cases:
  - P=0 or P=1 behaves exactly as P=2.
  - N=0 gives no shift strobes and stop_strobe in cycle H+P.
- Abort:
  - P=4, N=8, abort sampled in cycle 15: no strobes after cycle 14, busy low from cycle 16.
  - abort and start together in IDLE: busy stays 0.
- Mid-frame input changes:
  - start re-pulsed during DATA: timing is unchanged from the second scenario.
  - clks_per_bit changed to 10 mid-frame: still has no effect.
- Back-to-back: second start at edge 39 after a P=4, N=8 frame produces an identical frame offset by 39 cycles.
